// File: rtl/tree_sequencer.sv
// Inference control sequencer: gathers NUM_FEATURES words from the input buffer,
// kicks the tree evaluator, waits (with optional timeout) and publishes the class.
module tree_sequencer #(
  parameter int DATA_WIDTH   = 8,
  parameter int NUM_FEATURES = 4,
  parameter int FIDX_WIDTH   = 2,
  parameter int CLASS_WIDTH  = 2,
  parameter int TIMEOUT      = 255
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               enable,
  input  logic [DATA_WIDTH-1:0]              buf_data,
  input  logic                               buf_ready,
  output logic                               buf_processed,
  output logic [NUM_FEATURES*DATA_WIDTH-1:0] feat_vector,
  output logic                               eval_start,
  input  logic                               eval_done,
  input  logic [CLASS_WIDTH-1:0]             eval_class,
  output logic [CLASS_WIDTH-1:0]             result_class,
  output logic                               result_valid,
  output logic [7:0]                         done_count,
  output logic                               busy,
  output logic                               error,
  output logic [2:0]                         dbg_state
);

  // Handshakes: buf_processed is a level request held in REQ; a buf_ready strobe
  // seen in REQ is accepted and buf_data is sampled on the following edge.
  // eval_start is a single-cycle pulse; eval_done/eval_class count only in WAIT.

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] T_LAST = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;
  localparam logic [FIDX_WIDTH-1:0] LAST_IDX = FIDX_WIDTH'(NUM_FEATURES - 1);
  localparam bit TIMEOUT_EN = (TIMEOUT != 0);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_CAPT  = 3'd2,
    S_START = 3'd3,
    S_WAIT  = 3'd4
  } state_t;

  state_t                  state;
  state_t                  next_state;
  logic [FIDX_WIDTH-1:0]   idx;
  logic [TW-1:0]           timer;
  logic                    last_word;
  logic                    timeout_hit;
  logic                    finish_ok;
  logic                    finish_to;

  logic                    bp_d;
  logic                    start_d;
  logic                    busy_d;
  logic                    rvalid_d;
  logic [CLASS_WIDTH-1:0]  rclass_d;
  logic [7:0]              count_d;
  logic                    error_d;

  assign last_word   = (idx == LAST_IDX);
  assign timeout_hit = TIMEOUT_EN && (timer == T_LAST);
  // eval_done takes priority over an expiry landing on the same edge
  assign finish_ok   = (state == S_WAIT) && eval_done;
  assign finish_to   = (state == S_WAIT) && !eval_done && timeout_hit;
  assign dbg_state   = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (enable)    next_state = S_REQ;
      S_REQ:   if (buf_ready) next_state = S_CAPT;
      S_CAPT:  next_state = last_word ? S_START : S_REQ;
      S_START: next_state = S_WAIT;
      S_WAIT:  if (finish_ok || finish_to) next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Outputs are registered, so their D-inputs are derived from next_state.
  always_comb begin
    bp_d     = (next_state == S_REQ);
    start_d  = (next_state == S_START);
    busy_d   = (next_state != S_IDLE);
    rvalid_d = finish_ok;
    rclass_d = finish_ok ? eval_class : result_class;
    count_d  = finish_ok ? done_count + 8'd1 : done_count;
    error_d  = error | finish_to;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      buf_processed <= 1'b0;
      eval_start    <= 1'b0;
      busy          <= 1'b0;
      result_valid  <= 1'b0;
      result_class  <= '0;
      done_count    <= 8'd0;
      error         <= 1'b0;
    end else begin
      buf_processed <= bp_d;
      eval_start    <= start_d;
      busy          <= busy_d;
      result_valid  <= rvalid_d;
      result_class  <= rclass_d;
      done_count    <= count_d;
      error         <= error_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx         <= '0;
      timer       <= '0;
      feat_vector <= '0;
    end else begin
      if (state == S_CAPT) begin
        idx <= last_word ? '0 : idx + 1'b1;
        for (int k = 0; k < NUM_FEATURES; k++) begin
          if (idx == FIDX_WIDTH'(k)) begin
            feat_vector[k*DATA_WIDTH +: DATA_WIDTH] <= buf_data;
          end
        end
      end
      if (state == S_START) begin
        timer <= '0;
      end else if (state == S_WAIT && !eval_done && !timeout_hit) begin
        timer <= timer + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_tree_sequencer.sv
// Randomized bench for tree_sequencer: buffer and evaluator models drive the DUT,
// a per-inference outcome model feeds a scoreboard checked at every end of inference.
module tb_tree_sequencer;

  localparam int DW = 8;
  localparam int NF = 4;
  localparam int CW = 2;
  localparam int TO = 10;
  localparam int FW = NF * DW;
  localparam int EW = 1 + CW + 8 + 1 + FW;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b0;
  logic [DW-1:0] buf_data = '0;
  logic          buf_ready = 1'b0;
  logic          eval_done = 1'b0;
  logic [CW-1:0] eval_class = '0;
  logic          buf_processed;
  logic [FW-1:0] feat_vector;
  logic          eval_start;
  logic [CW-1:0] result_class;
  logic          result_valid;
  logic [7:0]    done_count;
  logic          busy;
  logic          error;
  logic [2:0]    dbg_state;

  always #5 clk = ~clk;

  tree_sequencer #(
    .DATA_WIDTH(DW), .NUM_FEATURES(NF), .FIDX_WIDTH(2), .CLASS_WIDTH(CW), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .buf_data(buf_data), .buf_ready(buf_ready),
    .buf_processed(buf_processed), .feat_vector(feat_vector), .eval_start(eval_start),
    .eval_done(eval_done), .eval_class(eval_class), .result_class(result_class),
    .result_valid(result_valid), .done_count(done_count), .busy(busy), .error(error),
    .dbg_state(dbg_state)
  );

  int total = 0;
  int bad = 0;
  // expected record: {timed_out, class, done_count, error, feat_vector}
  logic [EW-1:0] exp_q[$];
  int            dly_q[$];
  logic [CW-1:0] cls_q[$];
  logic [7:0]    m_count = 8'd0;
  logic          m_err = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Evaluator model: answers d edges after WAIT entry, or never when d == 0.
  initial begin : evaluator
    int d;
    logic [CW-1:0] c;
    forever begin
      @(negedge clk);
      if (!reset && eval_start) begin
        if (dly_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL eval_start: pulse with no inference queued (t=%0t)", $time);
        end else begin
          d = dly_q.pop_front();
          c = cls_q.pop_front();
          @(posedge clk);
          if (d != 0) begin
            repeat (d - 1) @(posedge clk);
            #1;
            eval_done  = 1'b1;
            eval_class = c;
            @(posedge clk);
            #1;
            eval_done  = 1'b0;
            eval_class = CW'($urandom_range(0, 3));
          end
        end
      end
    end
  end

  // Monitor: every busy fall ends one inference; compare against the oldest expectation.
  initial begin : monitor
    logic          prev_busy;
    int            start_cnt;
    logic [EW-1:0] e;
    prev_busy = 1'b0;
    start_cnt = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_busy = 1'b0;
        start_cnt = 0;
      end else begin
        if (eval_start) start_cnt++;
        if (prev_busy && !busy) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL inference_end: unexpected end of inference (t=%0t)", $time);
          end else begin
            e = exp_q.pop_front();
            check("result_valid", 64'(result_valid), 64'(!e[EW-1]));
            if (!e[EW-1]) check("result_class", 64'(result_class), 64'(e[EW-2 -: CW]));
            check("done_count", 64'(done_count), 64'(e[FW+8 -: 8]));
            check("error", 64'(error), 64'(e[FW]));
            check("feat_vector", 64'(feat_vector), 64'(e[FW-1:0]));
            check("eval_start_pulses", 64'(start_cnt), 64'd1);
          end
          start_cnt = 0;
        end else if (result_valid) begin
          total++;
          bad++;
          $display("FAIL result_valid: pulse outside end of inference (t=%0t)", $time);
        end
        prev_busy = busy;
      end
    end
  end

  task automatic wait_bp();
    int n = 0;
    while (!buf_processed && n < 100) begin
      tick();
      n++;
    end
    check("req_seen", 64'(buf_processed), 64'd1);
  endtask

  // Buffer model: strobe buf_ready, present the word one cycle later.
  task automatic send_word(input logic [DW-1:0] w, input int fill);
    wait_bp();
    repeat (fill) tick();
    buf_data  = ~w;
    buf_ready = 1'b1;
    tick();
    buf_ready = 1'b0;
    buf_data  = w;
    check("bp_drop", 64'(buf_processed), 64'd0);
    tick();
    buf_data = ~w;
  endtask

  task automatic run_inf(input logic [FW-1:0] feats, input logic [CW-1:0] c, input int d,
                         input bit keep_en, input bit fast);
    bit timed_out;
    bit spur;
    enable = 1'b1;
    for (int k = 0; k < NF; k++) begin
      send_word(feats[k*DW +: DW], fast ? 0 : int'($urandom_range(0, 2)));
      if (k == 0 && !keep_en) enable = 1'b0;
    end
    timed_out = (d == 0) || (d > TO);
    if (!timed_out) m_count = m_count + 8'd1;
    m_err = m_err | timed_out;
    exp_q.push_back({timed_out, (timed_out ? {CW{1'b0}} : c), m_count, m_err, feats});
    dly_q.push_back(d);
    cls_q.push_back(c);
    // stray buf_ready while the evaluator is working must be ignored
    spur = (d == 0) || (d >= 4);
    for (int i = 0; i < 40; i++) begin
      tick();
      if (spur && i == 1) buf_ready = 1'b1;
      if (i == 2) buf_ready = 1'b0;
      if (!busy) break;
    end
    buf_ready = 1'b0;
    check("end_seen", 64'(busy), 64'd0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_bp"}, 64'(buf_processed), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_start"}, 64'(eval_start), 64'd0);
    check({tag, "_rvalid"}, 64'(result_valid), 64'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_idle_outputs(tag);
    check({tag, "_class"}, 64'(result_class), 64'd0);
    check({tag, "_count"}, 64'(done_count), 64'd0);
    check({tag, "_error"}, 64'(error), 64'd0);
    check({tag, "_feat"}, 64'(feat_vector), 64'd0);
    check({tag, "_state"}, 64'(dbg_state), 64'd0);
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : driver
    logic [FW-1:0] f;
    bit keep;
    int r;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    reset = 1'b0;
    tick();

    run_inf(32'h44332211, 2'd2, 5, 1'b0, 1'b0);
    repeat (3) tick();
    check_idle_outputs("enable_low");

    f = $urandom();
    f[7:0] = 8'hA5;
    run_inf(f, 2'd3, 7, 1'b0, 1'b0);

    run_inf($urandom(), CW'($urandom_range(0, 3)), TO, 1'b0, 1'b0);
    run_inf($urandom(), 2'd0, 0, 1'b0, 1'b0);
    run_inf($urandom(), 2'd1, 3, 1'b0, 1'b0);

    for (int i = 0; i < 24; i++) begin
      keep = (i != 23) && ($urandom_range(0, 1) == 1);
      r = $urandom_range(0, 11);
      run_inf($urandom(), CW'($urandom_range(0, 3)), (r == 11) ? TO : r, keep, 1'b0);
      if (!keep) begin
        repeat (2) tick();
        check("no_new_req", 64'(buf_processed), 64'd0);
      end
    end

    // reset while the third word is being requested
    enable = 1'b1;
    send_word(8'h5A, 1);
    enable = 1'b0;
    send_word(8'hC3, 0);
    reset = 1'b1;
    #1;
    check_reset_outputs("midreset");
    exp_q.delete();
    m_count = 8'd0;
    m_err = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    tick();

    for (int i = 0; i < 256; i++) begin
      run_inf($urandom(), CW'($urandom_range(0, 3)), $urandom_range(1, 3), i != 255, 1'b1);
    end
    repeat (3) tick();
    check("wrap_count", 64'(done_count), 64'd0);
    check_idle_outputs("final");
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
